// File: rtl/reg_wb_arbiter.sv
// Round-robin writeback arbiter (A/M) for the reg_file write port, with a pending-write busy scoreboard.
// 1-cycle accept-to-write latency; ready is combinational from valids; optional write trace under WB_TRACE_EN.
module reg_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ADDR_W-1:0]      a_rd,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [ADDR_W-1:0]      m_rd,
  input  logic [DATA_W-1:0]      m_data,
  input  logic                   alloc_valid,
  input  logic [ADDR_W-1:0]      alloc_rd,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [ADDR_W-1:0]      rf_rd,
  output logic [DATA_W-1:0]      rf_write_data,
  output logic                   rf_reg_write
);

  localparam int NREG = 2**ADDR_W;

  logic              favour_m;
  logic              grant_a;
  logic              grant_m;
  logic              accept;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_nxt;

  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (!rst) begin
      if (a_valid && (!m_valid || !favour_m)) grant_a = 1'b1;
      else if (m_valid)                       grant_m = 1'b1;
    end
  end

  assign a_ready  = grant_a;
  assign m_ready  = grant_m;
  assign accept   = grant_a | grant_m;
  assign sel_rd   = grant_m ? m_rd   : a_rd;
  assign sel_data = grant_m ? m_data : a_data;

  // Clear for the retiring write first so a same-cycle allocation (new producer) wins.
  always_comb begin
    busy_nxt = busy;
    if (accept) busy_nxt[sel_rd] = 1'b0;
    if (alloc_valid && (alloc_rd != '0)) busy_nxt[alloc_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      favour_m      <= 1'b0;
      rf_reg_write  <= 1'b0;
      rf_rd         <= '0;
      rf_write_data <= '0;
      busy          <= '0;
    end else begin
      if (grant_a)      favour_m <= 1'b1;
      else if (grant_m) favour_m <= 1'b0;
      rf_reg_write <= accept && (sel_rd != '0);
      // r0 writes complete the handshake but leave the port untouched.
      if (accept && (sel_rd != '0)) begin
        rf_rd         <= sel_rd;
        rf_write_data <= sel_data;
      end
      busy <= busy_nxt;
    end
  end

`ifdef WB_TRACE_EN
  logic wr_src_m;

  always_ff @(posedge clk) begin
    if (rst)         wr_src_m <= 1'b0;
    else if (accept) wr_src_m <= grant_m;
    if (rf_reg_write)
      $display("wb: r%0d <= 0x%h from %s", rf_rd, rf_write_data, wr_src_m ? "M" : "A");
  end
`endif

endmodule
